// File: rtl/adpll_pkg.sv
// Shared ADPLL lock-controller definitions: state encoding, gain-select width
// and the default gear gains reused by NetworkADPLL test tops.
package adpll_pkg;

  localparam int GAIN_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_ACQUIRE = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_TRACK   = 3'd4
  } adpll_state_e;

  localparam logic [GAIN_W-1:0] KP_ACQ_DEF = 4'hC;
  localparam logic [GAIN_W-1:0] KI_ACQ_DEF = 4'hA;
  localparam logic [GAIN_W-1:0] KP_SHF_DEF = 4'h8;
  localparam logic [GAIN_W-1:0] KI_SHF_DEF = 4'h6;
  localparam logic [GAIN_W-1:0] KP_TRK_DEF = 4'h4;
  localparam logic [GAIN_W-1:0] KI_TRK_DEF = 4'h2;

  function automatic logic gear_active(input adpll_state_e s);
    return (s == ST_ACQUIRE) || (s == ST_SHIFT) || (s == ST_TRACK);
  endfunction

endpackage

// File: rtl/adpll_lock_detect.sv
// Phase-error window detector: saturating |error|, in/out-of-window compare and
// saturating consecutive-sample counters producing lock_hit / unlock_hit.
module adpll_lock_detect #(
  parameter int PDET_WIDTH    = 8,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [PDET_WIDTH-1:0] error,
  input  logic                         error_valid,
  input  logic                         lock_en,
  input  logic                         unlock_en,
  input  logic                         clr,
  output logic                         lock_hit,
  output logic                         unlock_hit
);

  localparam int CMAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [PDET_WIDTH-1:0] ERR_MAX = {1'b0, {(PDET_WIDTH-1){1'b1}}};

  logic [PDET_WIDTH-1:0] abs_err;
  logic                  in_win;
  logic                  out_win;
  logic [CW-1:0]         lock_cnt;
  logic [CW-1:0]         unlock_cnt;

  // The most negative code has no positive twin, so it clamps to full scale.
  function automatic logic [PDET_WIDTH-1:0] sat_abs(input logic signed [PDET_WIDTH-1:0] e);
    logic signed [PDET_WIDTH-1:0] neg;
    neg = -e;
    if (e[PDET_WIDTH-1] && neg[PDET_WIDTH-1]) return ERR_MAX;
    if (e[PDET_WIDTH-1]) return $unsigned(neg);
    return $unsigned(e);
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input int lim);
    return (32'(c) >= 32'(lim)) ? c : c + 1'b1;
  endfunction

  assign abs_err = sat_abs(error);
  assign in_win  = (32'(abs_err) <= 32'(LOCK_THRESH));
  assign out_win = (32'(abs_err) >  32'(UNLOCK_THRESH));

  // Hits fire on the strobe that completes the run, not one cycle later.
  assign lock_hit   = error_valid && lock_en && in_win &&
                      (32'(lock_cnt) >= 32'(LOCK_COUNT - 1));
  assign unlock_hit = error_valid && unlock_en && out_win &&
                      (32'(unlock_cnt) >= 32'(UNLOCK_COUNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      lock_cnt   <= '0;
      unlock_cnt <= '0;
    end else begin
      if (!lock_en)
        lock_cnt <= '0;
      else if (error_valid)
        lock_cnt <= in_win ? sat_inc(lock_cnt, LOCK_COUNT) : '0;

      if (!unlock_en)
        unlock_cnt <= '0;
      else if (error_valid)
        unlock_cnt <= out_win ? sat_inc(unlock_cnt, UNLOCK_COUNT) : '0;
    end
  end

endmodule

// File: rtl/adpll_gain_scheduler.sv
// Gear-shifting ADPLL lock controller: IDLE -> SETTLE -> ACQUIRE -> SHIFT -> TRACK
// with loss-of-lock fallback and manual kp/ki override of the gear gains.
module adpll_gain_scheduler
  import adpll_pkg::*;
#(
  parameter int PDET_WIDTH    = 8,
  parameter int SETTLE_CYCLES = 1024,
  parameter int LOCK_COUNT    = 16,
  parameter int UNLOCK_COUNT  = 4,
  parameter int LOCK_THRESH   = 8,
  parameter int UNLOCK_THRESH = 32,
  parameter logic [GAIN_W-1:0] KP_ACQ = KP_ACQ_DEF,
  parameter logic [GAIN_W-1:0] KI_ACQ = KI_ACQ_DEF,
  parameter logic [GAIN_W-1:0] KP_SHF = KP_SHF_DEF,
  parameter logic [GAIN_W-1:0] KI_SHF = KI_SHF_DEF,
  parameter logic [GAIN_W-1:0] KP_TRK = KP_TRK_DEF,
  parameter logic [GAIN_W-1:0] KI_TRK = KI_TRK_DEF
) (
  input  logic                         fpga_clk_i,
  input  logic                         rst_n_i,
  input  logic                         start_i,
  input  logic signed [PDET_WIDTH-1:0] error_i,
  input  logic                         error_valid_i,
  input  logic                         manual_i,
  input  logic [GAIN_W-1:0]            kp_manual_i,
  input  logic [GAIN_W-1:0]            ki_manual_i,
  output logic                         enable_o,
  output logic [GAIN_W-1:0]            kp_o,
  output logic [GAIN_W-1:0]            ki_o,
  output logic                         locked_o,
  output logic [2:0]                   state_o
);

  localparam int SW = $clog2(SETTLE_CYCLES) + 1;

  adpll_state_e      state_q;
  adpll_state_e      state_nxt;
  logic [SW-1:0]     settle_cnt;
  logic              settle_done;
  logic              lock_hit;
  logic              unlock_hit;
  logic              lock_en;
  logic              unlock_en;
  logic              cnt_clr;
  logic [GAIN_W-1:0] kp_gear;
  logic [GAIN_W-1:0] ki_gear;

  assign settle_done = (32'(settle_cnt) == 32'(SETTLE_CYCLES - 1));
  assign lock_en     = gear_active(state_q);
  assign unlock_en   = (state_q == ST_SHIFT) || (state_q == ST_TRACK);
  assign cnt_clr     = (state_nxt != state_q);
  assign state_o     = state_q;

  adpll_lock_detect #(
    .PDET_WIDTH   (PDET_WIDTH),
    .LOCK_COUNT   (LOCK_COUNT),
    .UNLOCK_COUNT (UNLOCK_COUNT),
    .LOCK_THRESH  (LOCK_THRESH),
    .UNLOCK_THRESH(UNLOCK_THRESH)
  ) u_lock_detect (
    .clk        (fpga_clk_i),
    .rst_n      (rst_n_i),
    .error      (error_i),
    .error_valid(error_valid_i),
    .lock_en    (lock_en),
    .unlock_en  (unlock_en),
    .clr        (cnt_clr),
    .lock_hit   (lock_hit),
    .unlock_hit (unlock_hit)
  );

  // Dropping start_i beats everything; loss of lock beats a gear-up.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_nxt = ST_SETTLE;
      ST_SETTLE:  if (settle_done) state_nxt = ST_ACQUIRE;
      ST_ACQUIRE: if (lock_hit) state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (unlock_hit)    state_nxt = ST_ACQUIRE;
        else if (lock_hit) state_nxt = ST_TRACK;
      end
      ST_TRACK:   if (unlock_hit) state_nxt = ST_ACQUIRE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (!start_i) state_nxt = ST_IDLE;
  end

  always_comb begin
    kp_gear = KP_ACQ;
    ki_gear = KI_ACQ;
    case (state_q)
      ST_SHIFT: begin
        kp_gear = KP_SHF;
        ki_gear = KI_SHF;
      end
      ST_TRACK: begin
        kp_gear = KP_TRK;
        ki_gear = KI_TRK;
      end
      default: ;
    endcase
    if (manual_i && gear_active(state_q)) begin
      kp_gear = kp_manual_i;
      ki_gear = ki_manual_i;
    end
  end

  // Outputs follow the registered state one cycle behind, except enable_o and
  // locked_o, which drop on the very edge that leaves the state.
  always_ff @(posedge fpga_clk_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      settle_cnt <= '0;
      enable_o   <= 1'b0;
      kp_o       <= KP_ACQ;
      ki_o       <= KI_ACQ;
      locked_o   <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      settle_cnt <= ((state_q == ST_SETTLE) && (state_nxt == ST_SETTLE)) ?
                    settle_cnt + 1'b1 : '0;
      enable_o   <= start_i && gear_active(state_q);
      kp_o       <= kp_gear;
      ki_o       <= ki_gear;
      locked_o   <= (state_q == ST_TRACK) && (state_nxt == ST_TRACK);
    end
  end

endmodule

// File: tb/tb_adpll_gain_scheduler.sv
// Scoreboard bench for adpll_gain_scheduler: expected output snapshots are queued
// as stimulus is applied and popped once the DUT has clocked that stimulus.
module tb_adpll_gain_scheduler;

  localparam int SETTLE_CYCLES = 1024;

  logic              fpga_clk_i = 1'b0;
  logic              rst_n_i;
  logic              start_i;
  logic signed [7:0] error_i;
  logic              error_valid_i;
  logic              manual_i;
  logic [3:0]        kp_manual_i;
  logic [3:0]        ki_manual_i;
  logic              enable_o;
  logic [3:0]        kp_o;
  logic [3:0]        ki_o;
  logic              locked_o;
  logic [2:0]        state_o;

  // Snapshot layout: {state, enable, kp, ki, locked}
  localparam logic [12:0] V_IDLE   = {3'd0, 1'b0, 4'hC, 4'hA, 1'b0};
  localparam logic [12:0] V_SETTLE = {3'd1, 1'b0, 4'hC, 4'hA, 1'b0};
  localparam logic [12:0] V_ACQ    = {3'd2, 1'b1, 4'hC, 4'hA, 1'b0};
  localparam logic [12:0] V_SHF    = {3'd3, 1'b1, 4'h8, 4'h6, 1'b0};
  localparam logic [12:0] V_TRK    = {3'd4, 1'b1, 4'h4, 4'h2, 1'b1};

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 fpga_clk_i = ~fpga_clk_i;

  adpll_gain_scheduler dut (
    .fpga_clk_i   (fpga_clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .error_i      (error_i),
    .error_valid_i(error_valid_i),
    .manual_i     (manual_i),
    .kp_manual_i  (kp_manual_i),
    .ki_manual_i  (ki_manual_i),
    .enable_o     (enable_o),
    .kp_o         (kp_o),
    .ki_o         (ki_o),
    .locked_o     (locked_o),
    .state_o      (state_o)
  );

  function automatic logic [12:0] snap();
    return {state_o, enable_o, kp_o, ki_o, locked_o};
  endfunction

  task automatic strobe(input int v);
    error_i       = v[7:0];
    error_valid_i = 1'b1;
    @(posedge fpga_clk_i); #1;
    error_valid_i = 1'b0;
  endtask

  task automatic idle(input int n);
    error_valid_i = 1'b0;
    repeat (n) begin
      @(posedge fpga_clk_i); #1;
    end
  endtask

  task automatic test_reset();
    exp_t e;
    logic [12:0] o;
    int k;
    rst_n_i = 1'b0; start_i = 1'b1; manual_i = 1'b0;
    kp_manual_i = 4'h0; ki_manual_i = 4'h0;
    error_i = 8'sd0; error_valid_i = 1'b0;
    exp_q.push_back('{"reset_hold", V_IDLE});
    repeat (5) begin
      @(posedge fpga_clk_i); #1;
    end
    e = exp_q.pop_front(); o = snap(); n_vec++;
    if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

    rst_n_i = 1'b1;
    exp_q.push_back('{"release_settle", V_SETTLE});
    idle(1);
    e = exp_q.pop_front(); o = snap(); n_vec++;
    if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end

    k = 0;
    while (enable_o !== 1'b1 && k < SETTLE_CYCLES + 64) begin
      @(posedge fpga_clk_i); #1;
      k++;
    end
    n_vec++;
    if (k != SETTLE_CYCLES + 1) begin
      n_bad++;
      $display("FAIL settle_len: got %0d cycles want %0d", k, SETTLE_CYCLES + 1);
    end
    exp_q.push_back('{"settle_to_acq", V_ACQ});
    e = exp_q.pop_front(); o = snap(); n_vec++;
    if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
  endtask

  task automatic test_lock_seq();
    exp_t e;
    logic [12:0] o;
    exp_q.push_back('{"acq_15", V_ACQ});
    exp_q.push_back('{"acq_to_shift", {3'd3, 1'b1, 4'hC, 4'hA, 1'b0}});
    exp_q.push_back('{"shift_gains", V_SHF});
    exp_q.push_back('{"shift_15", V_SHF});
    exp_q.push_back('{"shift_to_track", {3'd4, 1'b1, 4'h8, 4'h6, 1'b0}});
    exp_q.push_back('{"track_gains", V_TRK});
    for (int step = 0; step < 6; step++) begin
      case (step)
        0: repeat (15) strobe(3);
        1: strobe(3);
        2: idle(1);
        3: repeat (15) strobe(-8);
        4: strobe(-8);
        default: idle(1);
      endcase
      e = exp_q.pop_front(); o = snap(); n_vec++;
      if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_unlock();
    exp_t e;
    logic [12:0] o;
    exp_q.push_back('{"unlock_edge_32", V_TRK});
    exp_q.push_back('{"unlock_broken", V_TRK});
    exp_q.push_back('{"unlock_3", V_TRK});
    exp_q.push_back('{"track_to_acq", {3'd2, 1'b1, 4'h4, 4'h2, 1'b0}});
    exp_q.push_back('{"acq_gains", V_ACQ});
    for (int step = 0; step < 5; step++) begin
      case (step)
        0: begin repeat (3) strobe(33); strobe(32); end
        1: begin repeat (3) strobe(40); strobe(10); end
        2: repeat (3) strobe(-128);
        3: strobe(-128);
        default: idle(1);
      endcase
      e = exp_q.pop_front(); o = snap(); n_vec++;
      if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_lock_break();
    exp_t e;
    logic [12:0] o;
    exp_q.push_back('{"break_hold", V_ACQ});
    exp_q.push_back('{"break_shift", {3'd3, 1'b1, 4'hC, 4'hA, 1'b0}});
    exp_q.push_back('{"break_shift_gains", V_SHF});
    exp_q.push_back('{"back_to_track", V_TRK});
    for (int step = 0; step < 4; step++) begin
      case (step)
        0: begin repeat (15) strobe(2); strobe(9); repeat (15) strobe(2); end
        1: strobe(2);
        2: idle(1);
        default: begin repeat (16) strobe(0); idle(1); end
      endcase
      e = exp_q.pop_front(); o = snap(); n_vec++;
      if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_manual();
    exp_t e;
    logic [12:0] o;
    manual_i = 1'b1; kp_manual_i = 4'h3; ki_manual_i = 4'h1;
    exp_q.push_back('{"manual_track", {3'd4, 1'b1, 4'h3, 4'h1, 1'b1}});
    exp_q.push_back('{"manual_unlock", {3'd2, 1'b1, 4'h3, 4'h1, 1'b0}});
    exp_q.push_back('{"manual_shift", {3'd3, 1'b1, 4'h3, 4'h1, 1'b0}});
    exp_q.push_back('{"manual_to_track", {3'd4, 1'b1, 4'h3, 4'h1, 1'b0}});
    exp_q.push_back('{"manual_locked", {3'd4, 1'b1, 4'h3, 4'h1, 1'b1}});
    exp_q.push_back('{"manual_off", V_TRK});
    for (int step = 0; step < 6; step++) begin
      case (step)
        0: idle(1);
        1: repeat (4) strobe(-128);
        2: repeat (16) strobe(1);
        3: repeat (16) strobe(-1);
        4: idle(1);
        default: begin manual_i = 1'b0; idle(1); end
      endcase
      e = exp_q.pop_front(); o = snap(); n_vec++;
      if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [12:0] o;
    int k;
    exp_q.push_back('{"abort_track", {3'd0, 1'b0, 4'h4, 4'h2, 1'b0}});
    exp_q.push_back('{"abort_idle", V_IDLE});
    exp_q.push_back('{"restart_settle", V_SETTLE});
    exp_q.push_back('{"settle_mid", V_SETTLE});
    exp_q.push_back('{"abort_settle", V_IDLE});
    exp_q.push_back('{"restart_again", V_SETTLE});
    for (int step = 0; step < 6; step++) begin
      case (step)
        0: begin start_i = 1'b0; idle(1); end
        1: idle(1);
        2: begin start_i = 1'b1; idle(1); end
        3: begin error_i = 8'sd0; repeat (50) strobe(0); end
        4: begin start_i = 1'b0; idle(1); end
        default: begin start_i = 1'b1; idle(1); end
      endcase
      e = exp_q.pop_front(); o = snap(); n_vec++;
      if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
    end

    k = 0;
    while (enable_o !== 1'b1 && k < SETTLE_CYCLES + 64) begin
      @(posedge fpga_clk_i); #1;
      k++;
    end
    n_vec++;
    if (k != SETTLE_CYCLES + 1) begin
      n_bad++;
      $display("FAIL resettle_len: got %0d cycles want %0d", k, SETTLE_CYCLES + 1);
    end
    exp_q.push_back('{"resettle_acq", V_ACQ});
    e = exp_q.pop_front(); o = snap(); n_vec++;
    if (o !== e.v) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, o, e.v); end
  endtask

  initial begin
    test_reset();
    test_lock_seq();
    test_unlock();
    test_lock_break();
    test_manual();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog timeout");
  end

endmodule

// File: doc/adpll_gain_scheduler.md
Name: adpll_gain_scheduler

Overview:
Gear-shifting lock controller for one NetworkADPLL node or a whole ADPLL mesh. It sequences bring-up: the loop is held disabled while the reference settles, then enabled with high acquisition gains. Gains step down through SHIFT to low TRACK gains as the phase error stays small, and the block falls back to acquisition on loss of lock. Its outputs drive the node's enable_i, kp_i and ki_i selectors (4-bit kp/ki select codes, same encoding as the switch fields), with a manual switch override.

Parameters:
PDET_WIDTH, 8, width of signed phase-detector error
SETTLE_CYCLES, 1024, fpga_clk_i cycles with loop disabled after start
LOCK_COUNT, 16, consecutive in-window error samples needed to shift gear
UNLOCK_COUNT, 4, consecutive out-of-window samples needed to drop to ACQUIRE
LOCK_THRESH, 8, |error| <= this counts as in-window
UNLOCK_THRESH, 32, |error| > this counts as out-of-window
KP_ACQ / KI_ACQ, 4'hC / 4'hA, acquisition gain selects
KP_SHF / KI_SHF, 4'h8 / 4'h6, intermediate gain selects
KP_TRK / KI_TRK, 4'h4 / 4'h2, tracking gain selects

Ports:
fpga_clk_i  in  1  loop clock (258 MHz domain)
rst_n_i  in  1  synchronous reset, active low
start_i  in  1  level; 1 = run, 0 = return to IDLE next cycle
error_i  in  PDET_WIDTH  signed phase error from node
error_valid_i  in  1  one-cycle strobe, error_i sampled this cycle
manual_i  in  1  1 = gains taken from kp_manual_i/ki_manual_i
kp_manual_i  in  4  manual kp select
ki_manual_i  in  4  manual ki select
enable_o  out  1  loop enable to ADPLL
kp_o  out  4  kp select to ADPLL
ki_o  out  4  ki select to ADPLL
locked_o  out  1  1 in TRACK
state_o  out  3  encoded state for debug/7-seg

Behaviour:
- All outputs are registered. During reset and for the first cycle after it: state=IDLE, enable_o=0, kp_o=KP_ACQ, ki_o=KI_ACQ, locked_o=0, counters=0.
- abs_err = |error_i|. The value -2^(PDET_WIDTH-1) saturates to 2^(PDET_WIDTH-1)-1. Compare unsigned.
- States: IDLE=0, SETTLE=1, ACQUIRE=2, SHIFT=3, TRACK=4. Other codes are illegal and go to IDLE.
- IDLE: enable_o=0. When start_i=1, go to SETTLE and clear the settle counter.
- SETTLE: enable_o=0. The counter increments each cycle. At count==SETTLE_CYCLES-1, go to ACQUIRE and clear the lock/unlock counters.
- ACQUIRE / SHIFT / TRACK: enable_o=1. Gains are the state's gear values, or manual values when manual_i=1. Manual mode does not alter state transitions.
- On error_valid_i, for the lock counter:
  - abs_err<=LOCK_THRESH increments the lock counter.
  - Any other value clears the lock counter.
  - In ACQUIRE, lock counter reaching LOCK_COUNT goes to SHIFT. In SHIFT it goes to TRACK. Both counters clear on every state change.
- On error_valid_i, for the unlock counter:
  - abs_err>UNLOCK_THRESH increments the unlock counter.
  - Otherwise the unlock counter clears.
  - Reaching UNLOCK_COUNT in SHIFT or TRACK goes to ACQUIRE.
  - In ACQUIRE the unlock counter is ignored and held at 0.
- If lock and unlock conditions both hit in the same cycle, unlock wins. This is impossible while LOCK_THRESH<UNLOCK_THRESH; the priority is still documented.
- Counters saturate and do not wrap.
- start_i=0 in any non-IDLE state goes to IDLE next cycle and sets enable_o=0 that cycle. It overrides all other transitions.
- Latency: a state change happens on the clock edge that samples the qualifying strobe. enable_o, kp_o, ki_o and locked_o reflect the new state one cycle later.
- locked_o=1 only in TRACK. It is cleared in the same cycle as the transition out of TRACK.
- error_valid_i is ignored in IDLE and SETTLE.

Decomposition:
- Shared package adpll_pkg holds the state encoding constants (IDLE..TRACK), the gain-select width (4), and the default gear gain constants. NetworkADPLL test tops reuse these.
- One natural sub-module, adpll_lock_detect, contains the abs/saturate logic, window compare, and the saturating lock/unlock counters. It outputs lock_hit and unlock_hit pulses. The FSM and gain muxing stay in the top.

Test Plan:
- Reset: hold rst_n_i=0 with start_i=1 for 5 cycles -> enable_o=0, kp_o=4'hC, ki_o=4'hA, state_o=0. Release -> state_o=1 next cycle, enable_o=1 exactly SETTLE_CYCLES+1 cycles later.
- Lock sequence: 16 strobes of error=+3 -> SHIFT with kp/ki=8/6. 16 more strobes of error=-8 -> TRACK, kp/ki=4/2, locked_o=1.
- Lock break: 15 strobes of error=2, then one of error=9, then 15 of error=2 -> stays in ACQUIRE (counter cleared); a 16th strobe of 2 -> SHIFT.
- Unlock: in TRACK, 3 strobes of error=40 then one of 10 -> stays in TRACK. Then 4 strobes of error=-128 (saturated abs=127) -> ACQUIRE, locked_o=0, kp/ki=C/A.
- Manual override: manual_i=1, kp_manual_i=3, ki_manual_i=1 in TRACK -> kp_o=3, ki_o=1, locked_o still 1. The lock sequence continues to advance states.
- Abort: drop start_i mid-SETTLE and mid-TRACK -> IDLE next cycle, enable_o=0. Re-assert start_i -> full SETTLE count is repeated.
